// File: rtl/hkspi_pkg.sv
// hkspi_pkg: shared definitions for the housekeeping SPI slave.
//   - SPI command codes (stream write / stream read)
//   - register address map and reset values of the writable config bytes
//   - FSM state encoding
//   - helpers that classify and index config addresses
`timescale 1ns/1ps
package hkspi_pkg;

    // Command byte values
    localparam logic [7:0] CMD_WRITE = 8'h80;
    localparam logic [7:0] CMD_READ  = 8'h40;

    // Register addresses
    localparam logic [7:0] ADDR_STATUS    = 8'd0;
    localparam logic [7:0] ADDR_MFGR_HI   = 8'd1;
    localparam logic [7:0] ADDR_MFGR_LO   = 8'd2;
    localparam logic [7:0] ADDR_PROD      = 8'd3;
    localparam logic [7:0] ADDR_PROJ_3    = 8'd4;
    localparam logic [7:0] ADDR_PROJ_2    = 8'd5;
    localparam logic [7:0] ADDR_PROJ_1    = 8'd6;
    localparam logic [7:0] ADDR_PROJ_0    = 8'd7;
    localparam logic [7:0] ADDR_CFG_FIRST = 8'd8;
    localparam logic [7:0] ADDR_EXT_RESET = 8'd11;
    localparam logic [7:0] ADDR_CFG_LAST  = 8'd18;

    // Writable config bank: regs 8..18
    localparam int NUM_CFG       = 11;
    localparam int CFG_W         = NUM_CFG * 8;
    localparam int EXT_RESET_IDX = 3;          // reg11 within the config bank

    // Only bit 0 of reg11 is implemented
    localparam logic [7:0] EXT_RESET_MASK = 8'h01;

    // Reset values of the config registers
    localparam logic [7:0] RST_REG8  = 8'h02;
    localparam logic [7:0] RST_REG9  = 8'h01;
    localparam logic [7:0] RST_REG10 = 8'h00;
    localparam logic [7:0] RST_REG11 = 8'h00;
    localparam logic [7:0] RST_REG12 = 8'h00;
    localparam logic [7:0] RST_REG13 = 8'hff;
    localparam logic [7:0] RST_REG14 = 8'hef;
    localparam logic [7:0] RST_REG15 = 8'hff;
    localparam logic [7:0] RST_REG16 = 8'h03;
    localparam logic [7:0] RST_REG17 = 8'h12;
    localparam logic [7:0] RST_REG18 = 8'h04;

    // Reset image of the cfg bus, {reg18,...,reg8}
    localparam logic [CFG_W-1:0] CFG_RESET = {
        RST_REG18, RST_REG17, RST_REG16, RST_REG15, RST_REG14, RST_REG13,
        RST_REG12, RST_REG11, RST_REG10, RST_REG9,  RST_REG8
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_ADDR = 2'd2,
        ST_DATA = 2'd3
    } hk_state_e;

    function automatic logic is_cfg_addr(input logic [7:0] addr);
        return (addr >= ADDR_CFG_FIRST) && (addr <= ADDR_CFG_LAST);
    endfunction

    // Position of a config address inside the config bank (valid only when
    // is_cfg_addr() holds).
    function automatic logic [3:0] cfg_index(input logic [7:0] addr);
        logic [7:0] off;
        off = addr - ADDR_CFG_FIRST;
        return off[3:0];
    endfunction

endpackage

// File: rtl/hkspi_sync.sv
// hkspi_sync: brings the asynchronous SPI pins into the system clock domain.
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   sck       in   raw SPI clock
//   csb       in   raw SPI chip select (active low)
//   sdi       in   raw SPI data in
//   csb_s     out  synchronised chip select (resets high = deselected)
//   sdi_s     out  synchronised data in
//   sck_rise  out  one-cycle pulse on a synchronised sck rising edge
//   sck_fall  out  one-cycle pulse on a synchronised sck falling edge
`timescale 1ns/1ps
module hkspi_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    input  logic csb,
    input  logic sdi,
    output logic csb_s,
    output logic sdi_s,
    output logic sck_rise,
    output logic sck_fall
);

    logic sck_meta_q, sck_meta_d;
    logic sck_sync_q, sck_sync_d;
    logic sck_prev_q, sck_prev_d;
    logic csb_meta_q, csb_meta_d;
    logic csb_sync_q, csb_sync_d;
    logic sdi_meta_q, sdi_meta_d;
    logic sdi_sync_q, sdi_sync_d;

    always_comb begin
        sck_meta_d = sck;
        sck_sync_d = sck_meta_q;
        sck_prev_d = sck_sync_q;
        csb_meta_d = csb;
        csb_sync_d = csb_meta_q;
        sdi_meta_d = sdi;
        sdi_sync_d = sdi_meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_prev_q <= 1'b0;
            csb_meta_q <= 1'b1;
            csb_sync_q <= 1'b1;
            sdi_meta_q <= 1'b0;
            sdi_sync_q <= 1'b0;
        end else begin
            sck_meta_q <= sck_meta_d;
            sck_sync_q <= sck_sync_d;
            sck_prev_q <= sck_prev_d;
            csb_meta_q <= csb_meta_d;
            csb_sync_q <= csb_sync_d;
            sdi_meta_q <= sdi_meta_d;
            sdi_sync_q <= sdi_sync_d;
        end
    end

    // Edge pulses compare the synchronised level with its one-cycle-old copy,
    // so an edge is reported in the cycle after it reaches the sync stage.
    assign sck_rise = sck_sync_q & ~sck_prev_q;
    assign sck_fall = ~sck_sync_q & sck_prev_q;
    assign csb_s    = csb_sync_q;
    assign sdi_s    = sdi_sync_q;

endmodule

// File: rtl/vsdcaravel_hkspi.sv
// vsdcaravel_hkspi: housekeeping SPI slave of the vsdcaravel SoC.
// Decodes stream read (0x40) / stream write (0x80) commands on an oversampled
// SPI port and holds a 19-byte register file (ID, status, config).
//   clock      in   system clock, sole clock of the block
//   resetb     in   asynchronous active-low reset
//   sck        in   SPI clock (asynchronous to clock)
//   csb        in   SPI chip select, active low
//   sdi        in   SPI data in, MSB first
//   sdo        out  SPI data out, MSB first; 0 when not reading
//   sdo_oe     out  high only during the read-data phase while selected
//   ext_reset  out  reg11[0]; holds external/user logic in reset
//   cfg        out  config registers {reg18,...,reg8}
`timescale 1ns/1ps
module vsdcaravel_hkspi
    import hkspi_pkg::*;
#(
    parameter logic [11:0] MFGR_ID    = 12'h456,
    parameter logic [7:0]  PROD_ID    = 8'h11,
    parameter logic [31:0] PROJECT_ID = 32'h0000_0000
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             sck,
    input  logic             csb,
    input  logic             sdi,
    output logic             sdo,
    output logic             sdo_oe,
    output logic             ext_reset,
    output logic [CFG_W-1:0] cfg
);

    logic csb_s;
    logic sdi_s;
    logic sck_rise;
    // Data is both launched and captured on sck rise, so the fall pulse has
    // no consumer here.
    logic sck_fall_unused;

    hkspi_sync u_sync (
        .clk      (clock),
        .rst_n    (resetb),
        .sck      (sck),
        .csb      (csb),
        .sdi      (sdi),
        .csb_s    (csb_s),
        .sdi_s    (sdi_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall_unused)
    );

    hk_state_e                 state_q, state_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic [6:0]                shift_in_q, shift_in_d;
    logic [6:0]                shift_out_q, shift_out_d;
    logic [7:0]                addr_q, addr_d;
    logic                      wr_en_q, wr_en_d;
    logic                      rd_en_q, rd_en_d;
    logic                      sdo_q, sdo_d;
    logic                      sdo_oe_q, sdo_oe_d;
    logic [NUM_CFG-1:0][7:0]   cfg_q, cfg_d;

    logic [7:0] rx_byte;
    logic [7:0] addr_inc;
    logic [7:0] rd_addr_byte;
    logic [7:0] rd_next_byte;

    // Full register-file read mux; unmapped addresses read 0x00.
    function automatic logic [7:0] reg_read(input logic [7:0]              a,
                                            input logic [NUM_CFG-1:0][7:0] c);
        logic [7:0] r;
        case (a)
            ADDR_STATUS:  r = 8'h00;
            ADDR_MFGR_HI: r = {4'h0, MFGR_ID[11:8]};
            ADDR_MFGR_LO: r = MFGR_ID[7:0];
            ADDR_PROD:    r = PROD_ID;
            ADDR_PROJ_3:  r = PROJECT_ID[31:24];
            ADDR_PROJ_2:  r = PROJECT_ID[23:16];
            ADDR_PROJ_1:  r = PROJECT_ID[15:8];
            ADDR_PROJ_0:  r = PROJECT_ID[7:0];
            default: begin
                if (is_cfg_addr(a)) begin
                    r = c[cfg_index(a)];
                end else begin
                    r = 8'h00;
                end
            end
        endcase
        return r;
    endfunction

    always_comb begin
        // The byte completing on this rise: seven held bits plus the new one.
        rx_byte      = {shift_in_q, sdi_s};
        addr_inc     = addr_q + 8'd1;
        rd_addr_byte = reg_read(rx_byte, cfg_q);
        rd_next_byte = reg_read(addr_inc, cfg_q);

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        addr_d      = addr_q;
        wr_en_d     = wr_en_q;
        rd_en_d     = rd_en_q;
        sdo_d       = sdo_q;
        sdo_oe_d    = sdo_oe_q;
        cfg_d       = cfg_q;

        if (csb_s) begin
            // Deselect aborts everything, including a byte finishing this cycle.
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            wr_en_d   = 1'b0;
            rd_en_d   = 1'b0;
            sdo_d     = 1'b0;
            sdo_oe_d  = 1'b0;
        end else if (state_q == ST_IDLE) begin
            state_d   = ST_CMD;
            bit_cnt_d = 3'd0;
        end else if (sck_rise) begin
            shift_in_d = rx_byte[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;

            // Mid-byte read bits: next bit goes out on each rise.
            if (state_q == ST_DATA && rd_en_q && bit_cnt_q != 3'd7) begin
                sdo_d       = shift_out_q[6];
                shift_out_d = {shift_out_q[5:0], 1'b0};
            end

            if (bit_cnt_q == 3'd7) begin
                case (state_q)
                    ST_CMD: begin
                        wr_en_d = (rx_byte == CMD_WRITE);
                        rd_en_d = (rx_byte == CMD_READ);
                        state_d = ST_ADDR;
                    end
                    ST_ADDR: begin
                        addr_d  = rx_byte;
                        state_d = ST_DATA;
                        if (rd_en_q) begin
                            sdo_d       = rd_addr_byte[7];
                            shift_out_d = rd_addr_byte[6:0];
                            sdo_oe_d    = 1'b1;
                        end
                    end
                    ST_DATA: begin
                        addr_d = addr_inc;
                        if (wr_en_q && is_cfg_addr(addr_q)) begin
                            if (addr_q == ADDR_EXT_RESET) begin
                                cfg_d[cfg_index(addr_q)] = rx_byte & EXT_RESET_MASK;
                            end else begin
                                cfg_d[cfg_index(addr_q)] = rx_byte;
                            end
                        end
                        if (rd_en_q) begin
                            sdo_d       = rd_next_byte[7];
                            shift_out_d = rd_next_byte[6:0];
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_in_q  <= 7'd0;
            shift_out_q <= 7'd0;
            addr_q      <= 8'd0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            sdo_q       <= 1'b0;
            sdo_oe_q    <= 1'b0;
            cfg_q       <= CFG_RESET;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            sdo_q       <= sdo_d;
            sdo_oe_q    <= sdo_oe_d;
            cfg_q       <= cfg_d;
        end
    end

    assign sdo       = sdo_q;
    assign sdo_oe    = sdo_oe_q;
    assign ext_reset = cfg_q[EXT_RESET_IDX][0];
    assign cfg       = cfg_q;

endmodule

// File: tb/tb_vsdcaravel_hkspi.sv
`timescale 1ns/1ps
module tb_vsdcaravel_hkspi;

    logic        clock = 1'b0;
    logic        resetb;
    logic        sck;
    logic        csb;
    logic        sdi;
    logic        sdo;
    logic        sdo_oe;
    logic        ext_reset;
    logic [87:0] cfg;

    int   tests = 0;
    int   fails = 0;
    logic carry_bit;
    logic [7:0] rx;

    localparam logic [87:0] CFG_RST  = 88'h04_12_03_ff_ef_ff_00_00_00_01_02;
    localparam logic [87:0] CFG_WR13 = 88'h04_12_03_ff_55_aa_00_00_00_01_02;

    logic [7:0] exp_stream [19] = '{8'h00, 8'h04, 8'h56, 8'h11, 8'h00, 8'h00, 8'h00,
                                    8'h00, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'hff,
                                    8'hef, 8'hff, 8'h03, 8'h12, 8'h04};
    logic [7:0] exp_wrap [3] = '{8'h00, 8'h00, 8'h04};

    vsdcaravel_hkspi dut (
        .clock     (clock),
        .resetb    (resetb),
        .sck       (sck),
        .csb       (csb),
        .sdi       (sdi),
        .sdo       (sdo),
        .sdo_oe    (sdo_oe),
        .ext_reset (ext_reset),
        .cfg       (cfg)
    );

    always #12.5 clock = ~clock;

    task automatic check(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One SPI bit: 100 ns low, 100 ns high; sdo sampled just before the fall.
    task automatic spi_bit(input logic b, output logic s);
        sdi = b;
        #100;
        sck = 1'b1;
        #90;
        s = sdo;
        #10;
        sck = 1'b0;
    endtask

    // Read data for a byte is the bit seen after the previous byte's last
    // rise followed by the bits seen after rises 1..7 of this byte.
    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r);
        logic s;
        r[7] = carry_bit;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], s);
            if (i > 0) r[i-1] = s;
            else       carry_bit = s;
        end
    endtask

    task automatic cs_begin();
        csb = 1'b0;
        carry_bit = 1'b0;
        #100;
    endtask

    task automatic cs_end();
        #100;
        csb = 1'b1;
        #200;
    endtask

    task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
        logic [7:0] dummy;
        cs_begin();
        spi_byte(8'h40, dummy);
        spi_byte(a, dummy);
        spi_byte(8'h00, d);
        cs_end();
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        cs_begin();
        spi_byte(8'h80, dummy);
        spi_byte(a, dummy);
        spi_byte(d, dummy);
        cs_end();
    endtask

    initial begin
        logic s;
        resetb = 1'b0;
        sck = 1'b0;
        csb = 1'b1;
        sdi = 1'b0;
        carry_bit = 1'b0;
        #100;
        check("rst_sdo", 88'(sdo), 88'h0);
        check("rst_sdo_oe", 88'(sdo_oe), 88'h0);
        check("rst_ext_reset", 88'(ext_reset), 88'h0);
        check("rst_cfg", cfg, CFG_RST);
        resetb = 1'b1;
        #100;

        read_reg(8'h03, rx);
        check("read_reg3", 88'(rx), 88'h11);

        cs_begin();
        spi_byte(8'h40, rx);
        spi_byte(8'h00, rx);
        for (int k = 0; k < 19; k++) begin
            spi_byte(8'h00, rx);
            check($sformatf("stream_%0d", k), 88'(rx), 88'(exp_stream[k]));
            if (k == 0) check("stream_sdo_oe", 88'(sdo_oe), 88'h1);
        end
        cs_end();
        check("stream_sdo_oe_off", 88'(sdo_oe), 88'h0);

        cs_begin();
        spi_byte(8'h40, rx);
        spi_byte(8'hff, rx);
        for (int k = 0; k < 3; k++) begin
            spi_byte(8'h00, rx);
            check($sformatf("wrap_%0d", k), 88'(rx), 88'(exp_wrap[k]));
        end
        cs_end();

        write_reg(8'h0b, 8'h01);
        check("ext_reset_set", 88'(ext_reset), 88'h1);
        check("cfg_reg11_set", 88'(cfg[31:24]), 88'h01);
        write_reg(8'h0b, 8'hff);
        read_reg(8'h0b, rx);
        check("reg11_mask", 88'(rx), 88'h01);
        write_reg(8'h0b, 8'h00);
        check("ext_reset_clr", 88'(ext_reset), 88'h0);
        read_reg(8'h0b, rx);
        check("reg11_clr", 88'(rx), 88'h00);

        cs_begin();
        spi_byte(8'h80, rx);
        spi_byte(8'h0d, rx);
        spi_byte(8'haa, rx);
        spi_byte(8'h55, rx);
        cs_end();
        check("cfg_wr13_14", cfg, CFG_WR13);

        write_reg(8'h02, 8'h99);
        read_reg(8'h02, rx);
        check("ro_reg2", 88'(rx), 88'h56);

        cs_begin();
        spi_byte(8'h80, rx);
        spi_byte(8'h0c, rx);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, s);
        cs_end();
        check("partial_write", cfg, CFG_WR13);

        cs_begin();
        spi_byte(8'h20, rx);
        spi_byte(8'h03, rx);
        check("badcmd_oe", 88'(sdo_oe), 88'h0);
        spi_byte(8'h00, rx);
        check("badcmd_data", 88'(rx), 88'h00);
        check("badcmd_sdo", 88'(sdo), 88'h0);
        cs_end();
        check("badcmd_cfg", cfg, CFG_WR13);

        cs_begin();
        spi_byte(8'h40, rx);
        spi_byte(8'h0d, rx);
        spi_byte(8'h00, rx);
        check("prerst_reg13", 88'(rx), 88'haa);
        check("prerst_oe", 88'(sdo_oe), 88'h1);
        #50;
        resetb = 1'b0;
        #60;
        check("midrst_cfg", cfg, CFG_RST);
        check("midrst_oe", 88'(sdo_oe), 88'h0);
        check("midrst_sdo", 88'(sdo), 88'h0);
        check("midrst_ext_reset", 88'(ext_reset), 88'h0);
        resetb = 1'b1;
        cs_end();
        read_reg(8'h03, rx);
        check("postrst_reg3", 88'(rx), 88'h11);
        read_reg(8'h0d, rx);
        check("postrst_reg13", 88'(rx), 88'hff);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
